keccak_squeeze_buffer: RTL and testbench
========================================

Name: keccak_squeeze_buffer

Overview:
- Output-side counterpart of the absorb input buffer. It captures the rate portion of a permuted 1600-bit Keccak state and streams it out as 64-bit words (KEC_N) over a valid/ready interface.
- For digests longer than one rate block, it requests further permutations and keeps streaming from each new state.
- Sits between the keccak round core and the downstream digest consumer.

Parameters:
- KEC_N, 64, lane width in bits; equals OUT_BUF_SIZE.
- RATE_LANES, 17, lanes per rate block (17 = SHA3-256 / 1088 bits); legal range 1..25.
- OUT_LANES, 4, total 64-bit words emitted per squeeze (4 = 256-bit digest); legal range >= 1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- state_i  in  1600  flattened k_state; lane (x,y) at bits [(5*y+x)*64 +: 64].
- state_valid_i  in  1  state_i holds a freshly permuted state.
- state_ready_o  out  1  buffer will capture state_i this cycle if state_valid_i.
- squeeze_req_o  out  1  request for one more permutation of the current state.
- abort_i  in  1  drop the current squeeze, return to IDLE.
- dout_o  out  64  output lane, Keccak little-endian lane order, unmodified.
- dout_valid_o  out  1  dout_o valid.
- dout_ready_i  in  1  consumer accepts dout_o.
- dout_last_o  out  1  dout_o is word OUT_LANES-1 of this squeeze.
- busy_o  out  1  FSM not in IDLE.

Behaviour:
- Reset (rst=1, synchronous):
  - state <- IDLE; lane_cnt, out_cnt, capture register <- 0.
  - While rst is high: every output is 0, including state_ready_o.
- FSM states: IDLE, STREAM, WAIT_PERM.
- state_ready_o = 1 in IDLE and WAIT_PERM; 0 in STREAM.
- squeeze_req_o = 1 only in WAIT_PERM.
- busy_o = 1 in STREAM and WAIT_PERM.
- Capture:
  - Trigger: state_valid_i && state_ready_o.
  - Latch lanes with index i = x+5*y, 0..RATE_LANES-1, into the capture register; non-rate lanes are discarded.
  - lane_cnt <- 0; out_cnt <- 0 from IDLE, retained from WAIT_PERM; next state STREAM.
- Latency: capture in cycle N -> dout_valid_o=1 with lane 0 in cycle N+1.
- STREAM:
  - dout_valid_o=1, dout_o = capture lane[lane_cnt].
  - dout_last_o = (out_cnt == OUT_LANES-1).
- Handshake:
  - Transfer when dout_valid_o && dout_ready_i.
  - While dout_valid_o && !dout_ready_i, dout_o and dout_last_o hold stable.
  - dout_valid_o never deasserts without a transfer, except on abort_i or rst.
- On transfer in STREAM, in priority order:
  - If out_cnt == OUT_LANES-1 -> IDLE (squeeze done).
  - Else if lane_cnt == RATE_LANES-1 -> WAIT_PERM, out_cnt++.
  - Else lane_cnt++, out_cnt++.
- Exact boundary: if OUT_LANES == RATE_LANES, the last word is lane RATE_LANES-1 and the FSM goes directly to IDLE, never to WAIT_PERM.
- WAIT_PERM: dout_valid_o=0 and dout_o=0; hold until the capture condition fires, then STREAM.
- state_valid_i during STREAM is ignored; the capture register is unchanged.
- abort_i:
  - Takes priority over all transitions except rst.
  - In the next cycle: IDLE, counters 0, dout_valid_o=0, squeeze_req_o=0.
  - A transfer coinciding with abort_i counts as consumed.
  - No capture occurs in the abort cycle even if state_valid_i=1.
- dout_o and dout_last_o are 0 whenever dout_valid_o=0.
- Counter widths: lane_cnt $clog2(RATE_LANES), minimum 1 bit; out_cnt $clog2(OUT_LANES+1).
- All outputs derive from registers or FSM state only; no combinational path from any input to any output.

Test Plan:
- Defaults (17/4), state lane i = 64'h1000+i, dout_ready_i held 1, capture at cycle N -> dout_o 1000,1001,1002,1003 in cycles N+1..N+4; dout_last_o only with 1003; state_ready_o=1 in N+5; squeeze_req_o never asserted.
- Backpressure: dout_ready_i pattern 1,0,0,1,1,1 -> dout_o=1001 stable for 3 cycles; 4 words total; no duplicates or drops.
- Extended squeeze with OUT_LANES=20:
  - Words 1000..1010 (17 words); then WAIT_PERM with squeeze_req_o=1, state_ready_o=1.
  - Second state lane i = 64'h2000+i -> 2000,2001,2002; dout_last_o with 2002; then IDLE.
  - Repeat with OUT_LANES=17 -> last on 1010, no WAIT_PERM.
- state_valid_i pulsed with a different state while streaming word 1 -> ignored; remaining words still 1001..1003.
- abort_i on the cycle after word 1001 transfers -> next cycle dout_valid_o=0, state_ready_o=1; a new state with lanes 3000+i then streams 3000..3003 with dout_last_o on 3003 (out_cnt restarted).
- rst asserted in WAIT_PERM for 1 cycle -> all outputs 0 that cycle; IDLE afterwards with state_ready_o=1, busy_o=0; a subsequent capture streams from lane 0.

Source files
------------

// File: rtl/keccak_squeeze_buffer.sv
// keccak_squeeze_buffer
//   Captures the rate lanes of a freshly permuted 1600-bit Keccak state and
//   streams them out one KEC_N-bit lane per transfer over valid/ready. When the
//   digest needs more words than one rate block holds, it raises squeeze_req_o
//   and resumes streaming from the next permuted state.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   state_i         flattened state, lane i = x+5*y at [i*KEC_N +: KEC_N]
//   state_valid_i   state_i holds a freshly permuted state
//   state_ready_o   state_i is captured this cycle if state_valid_i
//   squeeze_req_o   asking the round core for one more permutation
//   abort_i         drop the current squeeze and return to idle
//   dout_o          output lane, Keccak lane order, unmodified
//   dout_valid_o    dout_o valid
//   dout_ready_i    consumer accepts dout_o
//   dout_last_o     dout_o is the final word of this squeeze
//   busy_o          a squeeze is in progress
//
// Every output is a flop loaded from the next-state decode, so the outputs
// follow the FSM state with no input-to-output combinational path, and they
// all read 0 in the cycle after a reset edge.
module keccak_squeeze_buffer #(
  parameter int KEC_N      = 64,
  parameter int RATE_LANES = 17,
  parameter int OUT_LANES  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [25*KEC_N-1:0] state_i,
  input  logic               state_valid_i,
  output logic               state_ready_o,
  output logic               squeeze_req_o,
  input  logic               abort_i,
  output logic [KEC_N-1:0]   dout_o,
  output logic               dout_valid_o,
  input  logic               dout_ready_i,
  output logic               dout_last_o,
  output logic               busy_o
);

  localparam int LANE_W = (RATE_LANES > 1) ? $clog2(RATE_LANES) : 1;
  localparam int OUT_W  = (OUT_LANES > 1) ? $clog2(OUT_LANES + 1) : 1;
  localparam int RATE_W = RATE_LANES * KEC_N;
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(RATE_LANES - 1);
  localparam logic [OUT_W-1:0]  OUT_LAST  = OUT_W'(OUT_LANES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STREAM    = 2'd1,
    WAIT_PERM = 2'd2
  } fsm_t;

  fsm_t              state, state_nxt;
  logic [LANE_W-1:0] lane_cnt, lane_nxt;
  logic [OUT_W-1:0]  out_cnt, out_nxt;
  logic [RATE_W-1:0] cap, cap_nxt;

  logic              capture, xfer;
  logic              ready_nxt, req_nxt, busy_nxt, valid_nxt, last_nxt;
  logic [KEC_N-1:0]  dout_nxt;

  // Capacity lanes never leave the core; only the rate portion is kept.
  generate
    if (RATE_LANES < 25) begin : g_unused
      logic unused_capacity;
      assign unused_capacity = ^state_i[25*KEC_N-1:RATE_W];
    end
  endgenerate

  // Next-state, counter and capture-register update, plus output decode.
  always_comb begin
    state_nxt = state;
    lane_nxt  = lane_cnt;
    out_nxt   = out_cnt;
    cap_nxt   = cap;
    capture   = state_valid_i && state_ready_o;
    xfer      = dout_valid_o && dout_ready_i;

    if (abort_i) begin
      // Abort wins over capture and transfer; a coinciding transfer is
      // simply treated as consumed.
      state_nxt = IDLE;
      lane_nxt  = {LANE_W{1'b0}};
      out_nxt   = {OUT_W{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (capture) begin
            cap_nxt   = state_i[RATE_W-1:0];
            lane_nxt  = {LANE_W{1'b0}};
            out_nxt   = {OUT_W{1'b0}};
            state_nxt = STREAM;
          end else begin
            state_nxt = IDLE;
          end
        end
        WAIT_PERM: begin
          // out_cnt keeps counting words across permutations.
          if (capture) begin
            cap_nxt   = state_i[RATE_W-1:0];
            lane_nxt  = {LANE_W{1'b0}};
            state_nxt = STREAM;
          end else begin
            state_nxt = WAIT_PERM;
          end
        end
        STREAM: begin
          // Digest completion is checked before rate exhaustion so that a
          // digest ending exactly on the last rate lane goes straight idle.
          if (xfer) begin
            if (out_cnt == OUT_LAST) begin
              state_nxt = IDLE;
            end else if (lane_cnt == LANE_LAST) begin
              state_nxt = WAIT_PERM;
              out_nxt   = out_cnt + OUT_W'(1);
            end else begin
              lane_nxt  = lane_cnt + LANE_W'(1);
              out_nxt   = out_cnt + OUT_W'(1);
            end
          end else begin
            state_nxt = STREAM;
          end
        end
        default: begin
          state_nxt = IDLE;
          lane_nxt  = {LANE_W{1'b0}};
          out_nxt   = {OUT_W{1'b0}};
        end
      endcase
    end

    ready_nxt = (state_nxt == IDLE) || (state_nxt == WAIT_PERM);
    req_nxt   = (state_nxt == WAIT_PERM);
    busy_nxt  = (state_nxt != IDLE);
    valid_nxt = (state_nxt == STREAM);

    dout_nxt = {KEC_N{1'b0}};
    if (valid_nxt) begin
      for (int i = 0; i < RATE_LANES; i++) begin
        if (lane_nxt == LANE_W'(i)) begin
          dout_nxt = cap_nxt[i*KEC_N +: KEC_N];
        end else begin
          dout_nxt = dout_nxt;
        end
      end
    end else begin
      dout_nxt = {KEC_N{1'b0}};
    end
    last_nxt = valid_nxt && (out_nxt == OUT_LAST);
  end

  // State, counters, capture register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      lane_cnt      <= {LANE_W{1'b0}};
      out_cnt       <= {OUT_W{1'b0}};
      cap           <= {RATE_W{1'b0}};
      state_ready_o <= 1'b0;
      squeeze_req_o <= 1'b0;
      busy_o        <= 1'b0;
      dout_valid_o  <= 1'b0;
      dout_o        <= {KEC_N{1'b0}};
      dout_last_o   <= 1'b0;
    end else begin
      state         <= state_nxt;
      lane_cnt      <= lane_nxt;
      out_cnt       <= out_nxt;
      cap           <= cap_nxt;
      state_ready_o <= ready_nxt;
      squeeze_req_o <= req_nxt;
      busy_o        <= busy_nxt;
      dout_valid_o  <= valid_nxt;
      dout_o        <= dout_nxt;
      dout_last_o   <= last_nxt;
    end
  end

endmodule

// File: tb/tb_keccak_squeeze_buffer.sv
// Directed scoreboard bench for keccak_squeeze_buffer. Three instances share
// the stimulus: OUT_LANES = 4 (default), 20 (multi-permutation) and 17 (digest
// ends exactly on the last rate lane). 'sel' picks which one is observed.
module tb_keccak_squeeze_buffer;

  logic          clk = 1'b0;
  logic          rst;
  logic [1599:0] state;
  logic          state_valid, abort, dout_ready;

  logic          sr [3];
  logic          rq [3];
  logic          dv [3];
  logic          dl [3];
  logic          bz [3];
  logic [63:0]   dd [3];

  always #5 clk = ~clk;

  keccak_squeeze_buffer #(.KEC_N(64), .RATE_LANES(17), .OUT_LANES(4)) u_d4 (
    .clk(clk), .rst(rst), .state_i(state), .state_valid_i(state_valid),
    .state_ready_o(sr[0]), .squeeze_req_o(rq[0]), .abort_i(abort),
    .dout_o(dd[0]), .dout_valid_o(dv[0]), .dout_ready_i(dout_ready),
    .dout_last_o(dl[0]), .busy_o(bz[0]));

  keccak_squeeze_buffer #(.KEC_N(64), .RATE_LANES(17), .OUT_LANES(20)) u_d20 (
    .clk(clk), .rst(rst), .state_i(state), .state_valid_i(state_valid),
    .state_ready_o(sr[1]), .squeeze_req_o(rq[1]), .abort_i(abort),
    .dout_o(dd[1]), .dout_valid_o(dv[1]), .dout_ready_i(dout_ready),
    .dout_last_o(dl[1]), .busy_o(bz[1]));

  keccak_squeeze_buffer #(.KEC_N(64), .RATE_LANES(17), .OUT_LANES(17)) u_d17 (
    .clk(clk), .rst(rst), .state_i(state), .state_valid_i(state_valid),
    .state_ready_o(sr[2]), .squeeze_req_o(rq[2]), .abort_i(abort),
    .dout_o(dd[2]), .dout_valid_o(dv[2]), .dout_ready_i(dout_ready),
    .dout_last_o(dl[2]), .busy_o(bz[2]));

  typedef struct packed {
    logic [63:0] d;
    logic        l;
  } exp_t;

  exp_t q[$];
  int   sel      = 0;
  int   checks   = 0;
  int   failures = 0;
  logic req_seen = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic load(input logic [63:0] base);
    for (int i = 0; i < 25; i++) state[i*64 +: 64] = base + 64'(i);
  endtask

  task automatic capture(input logic [63:0] base);
    load(base);
    state_valid = 1'b1;
    tick();
    state_valid = 1'b0;
  endtask

  // Queue n words base+0.. ; the final one carries last if fin is set.
  task automatic push_words(input logic [63:0] base, input int n, input logic fin);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e.d = base + 64'(k);
      e.l = fin && (k == n - 1);
      q.push_back(e);
    end
  endtask

  // Consume n words from the observed instance. pat gives dout_ready per
  // cycle for the first 16 cycles (1 afterwards); pulse_at injects a foreign
  // state with state_valid on that cycle.
  task automatic drain(input int n, input logic [15:0] pat, input int pulse_at);
    int          got  = 0;
    int          c    = 0;
    logic        hold = 1'b0;
    logic [63:0] hd   = 64'd0;
    logic        hl   = 1'b0;
    while (got < n && c < 200) begin
      dout_ready  = (c < 16) ? pat[c] : 1'b1;
      state_valid = (c == pulse_at);
      if (c == pulse_at) load(64'h5000);
      if (hold) begin
        chk("hold_valid", 64'(dv[sel]), 64'd1);
        chk("hold_data", dd[sel], hd);
        chk("hold_last", 64'(dl[sel]), 64'(hl));
      end
      if (rq[sel]) req_seen = 1'b1;
      if (dv[sel] && dout_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $error("FAIL extra_word observed=%h expected=none", dd[sel]);
        end else begin
          exp_t e = q.pop_front();
          chk("data", dd[sel], e.d);
          chk("last", 64'(dl[sel]), 64'(e.l));
        end
        got++;
        hold = 1'b0;
      end else begin
        hold = dv[sel];
        hd   = dd[sel];
        hl   = dl[sel];
      end
      tick();
      c++;
    end
    state_valid = 1'b0;
    dout_ready  = 1'b1;
    if (got < n) chk("timeout_words", 64'(got), 64'(n));
  endtask

  task automatic chk_outputs(input string tag, input logic r, input logic s,
                             input logic b, input logic v);
    chk({tag, "_ready"}, 64'(sr[sel]), 64'(r));
    chk({tag, "_req"}, 64'(rq[sel]), 64'(s));
    chk({tag, "_busy"}, 64'(bz[sel]), 64'(b));
    chk({tag, "_valid"}, 64'(dv[sel]), 64'(v));
  endtask

  initial begin
    rst         = 1'b1;
    state       = '0;
    state_valid = 1'b0;
    abort       = 1'b0;
    dout_ready  = 1'b1;

    // Reset state, then basic 4-word squeeze with ready held high.
    sel = 0;
    tick();
    chk_outputs("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_dout", dd[0], 64'd0);
    chk("rst_last", 64'(dl[0]), 64'd0);
    rst = 1'b0;
    tick();
    chk_outputs("idle", 1'b1, 1'b0, 1'b0, 1'b0);
    capture(64'h1000);
    chk("lat_valid", 64'(dv[0]), 64'd1);
    chk("lat_dout", dd[0], 64'h1000);
    push_words(64'h1000, 4, 1'b1);
    req_seen = 1'b0;
    drain(4, 16'hFFFF, -1);
    chk_outputs("done4", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("no_req4", 64'(req_seen), 64'd0);

    // Backpressure 1,0,0,1,1,1: word 1001 held for three cycles.
    do_reset();
    capture(64'h1000);
    push_words(64'h1000, 4, 1'b1);
    drain(4, 16'hFFF9, -1);
    chk("bp_qempty", 64'(q.size()), 64'd0);

    // Foreign state pulsed while word 1 is on the bus is ignored.
    do_reset();
    capture(64'h1000);
    push_words(64'h1000, 4, 1'b1);
    drain(4, 16'hFFFF, 1);
    chk_outputs("ign", 1'b1, 1'b0, 1'b0, 1'b0);

    // Abort after word 1001 transfers; a fresh squeeze restarts out_cnt.
    do_reset();
    capture(64'h1000);
    push_words(64'h1000, 2, 1'b0);
    drain(2, 16'hFFFF, -1);
    abort       = 1'b1;
    dout_ready  = 1'b0;
    load(64'h6000);
    state_valid = 1'b1;
    tick();
    abort       = 1'b0;
    state_valid = 1'b0;
    dout_ready  = 1'b1;
    chk_outputs("abort", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("abort_dout", dd[0], 64'd0);
    capture(64'h3000);
    push_words(64'h3000, 4, 1'b1);
    drain(4, 16'hFFFF, -1);
    chk("abort_qempty", 64'(q.size()), 64'd0);

    // OUT_LANES=20: 17 words, permutation request, 3 more words.
    sel = 1;
    do_reset();
    capture(64'h1000);
    push_words(64'h1000, 17, 1'b0);
    drain(17, 16'hFFFF, -1);
    chk_outputs("wait", 1'b1, 1'b1, 1'b1, 1'b0);
    chk("wait_dout", dd[1], 64'd0);
    tick();
    chk_outputs("wait2", 1'b1, 1'b1, 1'b1, 1'b0);
    capture(64'h2000);
    push_words(64'h2000, 3, 1'b1);
    drain(3, 16'hFFFF, -1);
    chk_outputs("done20", 1'b1, 1'b0, 1'b0, 1'b0);

    // OUT_LANES=17: last word is lane 16, never enters WAIT_PERM.
    sel = 2;
    do_reset();
    capture(64'h1000);
    push_words(64'h1000, 17, 1'b1);
    req_seen = 1'b0;
    drain(17, 16'hFFFF, -1);
    chk_outputs("done17", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("no_req17", 64'(req_seen), 64'd0);

    // Reset during WAIT_PERM, then a full 20-word squeeze from lane 0.
    sel = 1;
    do_reset();
    capture(64'h4000);
    push_words(64'h4000, 17, 1'b0);
    drain(17, 16'hFFFF, -1);
    chk("pre_rst_req", 64'(rq[1]), 64'd1);
    rst = 1'b1;
    tick();
    chk_outputs("wrst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wrst_dout", dd[1], 64'd0);
    chk("wrst_last", 64'(dl[1]), 64'd0);
    rst = 1'b0;
    tick();
    chk_outputs("post_rst", 1'b1, 1'b0, 1'b0, 1'b0);
    capture(64'h2000);
    push_words(64'h2000, 17, 1'b0);
    drain(17, 16'hFFFF, -1);
    chk("post_rst_req", 64'(rq[1]), 64'd1);
    capture(64'h7000);
    push_words(64'h7000, 3, 1'b1);
    drain(3, 16'hFFFF, -1);
    chk("final_qempty", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
